// File: rtl/urv_writeback_pkg.sv
// Shared definitions for the uRV writeback stage: load/store funct3 codes,
// rd source select encodings and writeback FSM states.
package urv_writeback_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_W  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   localparam logic [1:0] RD_SOURCE_ALU      = 2'd0;
   localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'd1;
   localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'd2;
   localparam logic [1:0] RD_SOURCE_CSR      = 2'd3;

   typedef enum logic [1:0] {
      WB_IDLE    = 2'd0,
      WB_WAIT_LD = 2'd1,
      WB_WAIT_ST = 2'd2
   } wb_state_t;

endpackage

// File: rtl/urv_load_align.sv
// Load data alignment: picks the byte/halfword lane addressed by addr and
// sign- or zero-extends it according to funct3. Purely combinational.
module urv_load_align
   import urv_writeback_pkg::*;
(
   input  logic [2:0]  fun,
   input  logic [1:0]  addr,
   input  logic [31:0] data,
   output logic [31:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      byte_sel = data[7:0];
      case (addr)
         2'd0: byte_sel = data[7:0];
         2'd1: byte_sel = data[15:8];
         2'd2: byte_sel = data[23:16];
         2'd3: byte_sel = data[31:24];
         default: byte_sel = data[7:0];
      endcase
      half_sel = addr[1] ? data[31:16] : data[15:0];

      value = '0;
      case (fun)
         LDST_B:  value = {{24{byte_sel[7]}}, byte_sel};
         LDST_BU: value = {24'h0, byte_sel};
         LDST_H:  value = {{16{half_sel[15]}}, half_sel};
         LDST_HU: value = {16'h0, half_sel};
         LDST_W:  value = data;
         default: value = '0;
      endcase
   end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback (W) stage: completes loads/stores, aligns load data, drives the
// register-file write port and a registered bypass entry. Define URV_WB_INSTRET_EN
// to build the retired-instruction counter on instret_o (tied to 0 otherwise).
module urv_writeback
   import urv_writeback_pkg::*;
#(
   parameter int INSTRET_WIDTH = 40
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     w_stall_i,
   input  logic                     w_valid_i,
   input  logic [2:0]               w_fun_i,
   input  logic                     w_load_i,
   input  logic                     w_store_i,
   input  logic [4:0]               w_rd_i,
   input  logic                     w_rd_write_i,
   input  logic [31:0]              w_rd_value_i,
   input  logic [31:0]              w_rd_shifter_i,
   input  logic [31:0]              w_rd_multiply_i,
   input  logic [1:0]               w_rd_source_i,
   input  logic [31:0]              w_dm_addr_i,
   input  logic [31:0]              dm_data_l_i,
   input  logic                     dm_load_done_i,
   input  logic                     dm_store_done_i,
   output logic                     w_stall_req_o,
   output logic [4:0]               rf_rd_o,
   output logic [31:0]              rf_rd_value_o,
   output logic                     rf_rd_write_o,
   output logic [4:0]               x_bypass_rd_o,
   output logic [31:0]              x_bypass_value_o,
   output logic                     x_bypass_write_o,
   output logic [INSTRET_WIDTH-1:0] instret_o
);

   wb_state_t   state;
   logic        cap_valid;
   logic [31:0] cap_data;
   logic [31:0] load_value;
   logic [31:0] result_value;
   logic        mem_ld, mem_st, ld_done, st_done, mem_done;
   logic        complete, retire;
   logic        unused_addr;

   assign unused_addr = ^w_dm_addr_i[31:2];

   urv_load_align u_load_align (
      .fun   (w_fun_i),
      .addr  (w_dm_addr_i[1:0]),
      .data  (dm_data_l_i),
      .value (load_value)
   );

   // A captured completion means the memory side is finished for this instruction.
   assign mem_ld = w_valid_i & w_load_i  & ~cap_valid;
   assign mem_st = w_valid_i & w_store_i & ~cap_valid;

   always_comb begin
      ld_done  = dm_load_done_i  & ((state == WB_WAIT_LD) | ((state == WB_IDLE) & mem_ld));
      st_done  = dm_store_done_i & ((state == WB_WAIT_ST) | ((state == WB_IDLE) & mem_st));
      mem_done = ld_done | st_done;

      w_stall_req_o = ((state == WB_WAIT_LD) & ~dm_load_done_i)
                    | ((state == WB_WAIT_ST) & ~dm_store_done_i)
                    | ((state == WB_IDLE) & ((mem_ld & ~dm_load_done_i) | (mem_st & ~dm_store_done_i)));

      complete = cap_valid | mem_done | ((state == WB_IDLE) & ~mem_ld & ~mem_st);
      retire   = complete & ~w_stall_i;

      result_value = w_rd_value_i;
      case (w_rd_source_i)
         RD_SOURCE_ALU:      result_value = w_rd_value_i;
         RD_SOURCE_SHIFTER:  result_value = w_rd_shifter_i;
         RD_SOURCE_MULTIPLY: result_value = w_rd_multiply_i;
         RD_SOURCE_CSR:      result_value = w_rd_value_i;
         default:            result_value = w_rd_value_i;
      endcase
   end

   assign rf_rd_o       = w_rd_i;
   assign rf_rd_value_o = w_load_i ? (cap_valid ? cap_data : load_value) : result_value;
   assign rf_rd_write_o = retire & w_rd_write_i & w_valid_i & (w_rd_i != 5'd0);

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state            <= WB_IDLE;
         cap_valid        <= 1'b0;
         cap_data         <= '0;
         x_bypass_rd_o    <= '0;
         x_bypass_value_o <= '0;
         x_bypass_write_o <= 1'b0;
      end else begin
         case (state)
            WB_IDLE:
               if (mem_ld & ~dm_load_done_i & ~w_stall_i)
                  state <= WB_WAIT_LD;
               else if (mem_st & ~dm_store_done_i & ~w_stall_i)
                  state <= WB_WAIT_ST;
            WB_WAIT_LD: if (dm_load_done_i)  state <= WB_IDLE;
            WB_WAIT_ST: if (dm_store_done_i) state <= WB_IDLE;
            default:    state <= WB_IDLE;
         endcase

         // Completion while the pipeline is frozen is held until the stall drops.
         if (mem_done & w_stall_i) begin
            cap_valid <= 1'b1;
            cap_data  <= load_value;
         end else if (retire) begin
            cap_valid <= 1'b0;
         end

         if (retire) begin
            x_bypass_write_o <= rf_rd_write_o;
            if (rf_rd_write_o) begin
               x_bypass_rd_o    <= w_rd_i;
               x_bypass_value_o <= rf_rd_value_o;
            end
         end
      end
   end

`ifdef URV_WB_INSTRET_EN
   logic [INSTRET_WIDTH-1:0] instret;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         instret <= '0;
      else if (retire & w_valid_i)
         instret <= instret + 1'b1;
   end

   assign instret_o = instret;
`else
   assign instret_o = '0;
`endif

endmodule

// File: tb/tb_urv_writeback.sv
// Self-checking bench for urv_writeback: directed scenarios plus randomized
// instruction stream against a transaction-level reference model.
module tb_urv_writeback;

   localparam int IW = 40;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          w_stall_i, w_valid_i, w_load_i, w_store_i, w_rd_write_i;
   logic [2:0]    w_fun_i;
   logic [4:0]    w_rd_i;
   logic [31:0]   w_rd_value_i, w_rd_shifter_i, w_rd_multiply_i, w_dm_addr_i, dm_data_l_i;
   logic [1:0]    w_rd_source_i;
   logic          dm_load_done_i, dm_store_done_i;
   logic          w_stall_req_o, rf_rd_write_o, x_bypass_write_o;
   logic [4:0]    rf_rd_o, x_bypass_rd_o;
   logic [31:0]   rf_rd_value_o, x_bypass_value_o;
   logic [IW-1:0] instret_o;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [4:0]    m_byp_rd;
   logic [31:0]   m_byp_val;
   logic          m_byp_wr;
   logic [IW-1:0] m_instret;
   logic [31:0]   last_val;

   urv_writeback #(.INSTRET_WIDTH(IW)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .w_stall_i(w_stall_i), .w_valid_i(w_valid_i),
      .w_fun_i(w_fun_i), .w_load_i(w_load_i), .w_store_i(w_store_i), .w_rd_i(w_rd_i),
      .w_rd_write_i(w_rd_write_i), .w_rd_value_i(w_rd_value_i), .w_rd_shifter_i(w_rd_shifter_i),
      .w_rd_multiply_i(w_rd_multiply_i), .w_rd_source_i(w_rd_source_i), .w_dm_addr_i(w_dm_addr_i),
      .dm_data_l_i(dm_data_l_i), .dm_load_done_i(dm_load_done_i), .dm_store_done_i(dm_store_done_i),
      .w_stall_req_o(w_stall_req_o), .rf_rd_o(rf_rd_o), .rf_rd_value_o(rf_rd_value_o),
      .rf_rd_write_o(rf_rd_write_o), .x_bypass_rd_o(x_bypass_rd_o),
      .x_bypass_value_o(x_bypass_value_o), .x_bypass_write_o(x_bypass_write_o),
      .instret_o(instret_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] a,
                                            input logic [31:0] d);
      logic [31:0] b, h;
      b = (d >> (8 * a)) & 32'hFF;
      h = (d >> (16 * a[1])) & 32'hFFFF;
      case (f)
         3'd0:    return b[7]  ? (b | 32'hFFFFFF00) : b;
         3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
         3'd2:    return d;
         3'd4:    return b;
         3'd5:    return h;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [IW-1:0] exp_instret();
`ifdef URV_WB_INSTRET_EN
      return m_instret;
`else
      return '0;
`endif
   endfunction

   task automatic check_regs();
      check("byp_rd", x_bypass_rd_o, m_byp_rd);
      check("byp_value", x_bypass_value_o, m_byp_val);
      check("byp_write", x_bypass_write_o, m_byp_wr);
      check("instret", instret_o, exp_instret());
   endtask

   task automatic model_reset();
      m_byp_rd = '0; m_byp_val = '0; m_byp_wr = 1'b0; m_instret = '0;
   endtask

   task automatic drive_idle(input logic stall);
      w_stall_i = stall; w_valid_i = 0; w_fun_i = 0; w_load_i = 0; w_store_i = 0;
      w_rd_i = 0; w_rd_write_i = 0; w_rd_value_i = 0; w_rd_shifter_i = 0;
      w_rd_multiply_i = 0; w_rd_source_i = 0; w_dm_addr_i = 0; dm_data_l_i = 0;
      dm_load_done_i = 0; dm_store_done_i = 0;
   endtask

   // Present one instruction until it retires. Memory done arrives `lat` cycles
   // after presentation; stall_mask bit i forces the global stall in cycle i.
   task automatic do_instr(input logic valid, input logic ld, input logic st, input logic [2:0] fun,
                           input logic [4:0] rd, input logic wr, input logic [1:0] src,
                           input logic [31:0] addr, input logic [31:0] data, input logic [31:0] val,
                           input logic [31:0] shf, input logic [31:0] mul, input int lat,
                           input logic [7:0] stall_mask, output int req_cycles);
      logic mem, got_done, done_now, exp_req, exp_ret, exp_wr, retired;
      logic [31:0] exp_val;
      mem = valid && (ld || st);
      if (ld)               exp_val = ref_load(fun, addr[1:0], data);
      else if (src == 2'd1) exp_val = shf;
      else if (src == 2'd2) exp_val = mul;
      else                  exp_val = val;
      got_done = 0; retired = 0; req_cycles = 0;
      for (int cyc = 0; cyc < 24; cyc++) begin
         @(negedge clk_i);
         w_valid_i = valid; w_load_i = ld; w_store_i = st; w_fun_i = fun; w_rd_i = rd;
         w_rd_write_i = wr; w_rd_source_i = src; w_dm_addr_i = addr; w_rd_value_i = val;
         w_rd_shifter_i = shf; w_rd_multiply_i = mul;
         w_stall_i = (cyc < 8) ? stall_mask[cyc] : 1'b0;
         done_now = mem && (cyc == lat);
         dm_load_done_i  = done_now && ld;
         dm_store_done_i = done_now && st;
         dm_data_l_i = done_now ? data : $urandom;
         #1;
         exp_req = mem && !got_done && !done_now;
         exp_ret = (!mem || got_done || done_now) && !w_stall_i;
         exp_wr  = exp_ret && wr && valid && (rd != 5'd0);
         check("stall_req", w_stall_req_o, exp_req);
         check("rf_write", rf_rd_write_o, exp_wr);
         if (exp_wr) begin
            check("rf_rd", rf_rd_o, rd);
            check("rf_value", rf_rd_value_o, exp_val);
            last_val = rf_rd_value_o;
         end
         check_regs();
         if (exp_req) req_cycles++;
         if (done_now) got_done = 1;
         if (exp_ret) begin
            if (exp_wr) begin m_byp_rd = rd; m_byp_val = exp_val; end
            m_byp_wr = exp_wr;
            if (valid) m_instret = m_instret + 1'b1;
            retired = 1;
            break;
         end
      end
      if (!retired) check("retire_timeout", 0, 1);
   endtask

   initial begin
      int req;
      logic [7:0] before_inst;
      rst_n_i = 1'b0;
      drive_idle(1'b0);
      model_reset();
      last_val = '0;
      #12;
      check("rst_stall_req", w_stall_req_o, 0);
      check("rst_rf_write", rf_rd_write_o, 0);
      check_regs();
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // Zero-wait byte loads
      do_instr(1, 1, 0, 3'd0, 5'd3, 1, 2'd0, 32'h1003, 32'h80FF1234, 0, 0, 0, 0, 8'h00, req);
      check("lb_value", last_val, 32'hFFFFFF80);
      check("lb_req_cycles", req, 0);
      do_instr(1, 1, 0, 3'd4, 5'd4, 1, 2'd0, 32'h1003, 32'h80FF1234, 0, 0, 0, 0, 8'h00, req);
      check("lbu_value", last_val, 32'h00000080);

      // Halfword loads acknowledged three cycles late
      do_instr(1, 1, 0, 3'd1, 5'd6, 1, 2'd0, 32'h2002, 32'h80FF1234, 0, 0, 0, 3, 8'h00, req);
      check("lh_value", last_val, 32'hFFFF80FF);
      check("lh_req_cycles", req, 3);
      do_instr(1, 1, 0, 3'd5, 5'd7, 1, 2'd0, 32'h2002, 32'h80FF1234, 0, 0, 0, 3, 8'h00, req);
      check("lhu_value", last_val, 32'h000080FF);
      check("lhu_req_cycles", req, 3);

      // Word load completing under stall: value comes from the capture register
      do_instr(1, 1, 0, 3'd2, 5'd8, 1, 2'd0, 32'h0, 32'hCAFEF00D, 0, 0, 0, 0, 8'h03, req);
      check("lw_capture_value", last_val, 32'hCAFEF00D);

      // Load to x0 never writes
      before_inst = instret_o[7:0];
      do_instr(1, 1, 0, 3'd2, 5'd0, 1, 2'd0, 32'h0, 32'h12345678, 0, 0, 0, 1, 8'h00, req);

      // Store whose done lands while stalled
      do_instr(1, 0, 1, 3'd2, 5'd9, 0, 2'd0, 32'h40, 32'h0, 0, 0, 0, 1, 8'h06, req);

      // Shifter result and bypass one cycle later
      do_instr(1, 0, 0, 3'd0, 5'd5, 1, 2'd1, 32'h0, 32'h0, 32'h11111111, 32'hDEADBEEF, 32'h22222222,
               0, 8'h00, req);
      check("shifter_value", last_val, 32'hDEADBEEF);
      @(negedge clk_i);
      drive_idle(1'b1);
      #1;
      check("byp_rd_5", x_bypass_rd_o, 5);
      check("byp_value_dead", x_bypass_value_o, 32'hDEADBEEF);
      check("byp_write_1", x_bypass_write_o, 1);
`ifdef URV_WB_INSTRET_EN
      check("instret_count", instret_o[7:0], before_inst + 8'd3);
`endif

      // Randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         logic v, ld, st;
         logic [2:0] f;
         logic [31:0] a;
         int kind;
         logic [2:0] funs [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
         kind = $urandom_range(0, 2);
         v  = ($urandom_range(0, 7) != 0);
         ld = (kind == 1);
         st = (kind == 2);
         f  = funs[$urandom_range(0, 5)];
         a  = $urandom;
         if (f == 3'd1 || f == 3'd5) a[0] = 1'b0;
         if (f == 3'd2) a[1:0] = 2'b00;
         do_instr(v, ld, st, f, 5'($urandom), 1'($urandom), 2'($urandom), a, $urandom,
                  $urandom, $urandom, $urandom, $urandom_range(0, 4),
                  8'($urandom & $urandom), req);
      end

      // Reset while a load is outstanding, then a stray done
      @(negedge clk_i);
      drive_idle(1'b0);
      w_valid_i = 1; w_load_i = 1; w_rd_i = 5'd10; w_rd_write_i = 1; w_fun_i = 3'd2;
      @(negedge clk_i);
      #1;
      check("wait_ld_stall_req", w_stall_req_o, 1);
      rst_n_i = 1'b0;
      drive_idle(1'b0);
      #1;
      check("mid_rst_stall_req", w_stall_req_o, 0);
      check("mid_rst_rf_write", rf_rd_write_o, 0);
      check("mid_rst_rf_rd", rf_rd_o, 0);
      check("mid_rst_rf_value", rf_rd_value_o, 0);
      model_reset();
      check_regs();
      @(negedge clk_i);
      rst_n_i = 1'b1;
      dm_load_done_i = 1'b1;
      #1;
      check("stray_done_stall_req", w_stall_req_o, 0);
      check("stray_done_rf_write", rf_rd_write_o, 0);
      @(negedge clk_i);
      dm_load_done_i = 1'b0;
      #1;
      check_regs();

      // Back in IDLE: plain ALU op must not see a stall
      do_instr(1, 0, 0, 3'd0, 5'd12, 1, 2'd2, 0, 0, 32'h1, 32'h2, 32'h00C0FFEE, 0, 8'h00, req);
      check("post_rst_value", last_val, 32'h00C0FFEE);
      for (int n = 0; n < 20; n++)
         do_instr(1, 1, 0, 3'd2, 5'($urandom), 1, 2'd0, 0, $urandom, 0, 0, 0,
                  $urandom_range(0, 3), 8'($urandom), req);
      @(negedge clk_i);
      drive_idle(1'b0);
      #1;
      check_regs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/urv_writeback.md
Name: urv_writeback

Overview:
- Final (W) pipeline stage, directly downstream of the execute stage.
- Consumes the X/W pipeline registers and completes outstanding data-memory transactions.
- Aligns and sign-extends load data, selects the rd source, drives the register-file write port and publishes a registered forwarding copy for decode.
- Raises a stall request while a load or store is waiting for its memory acknowledge.

Parameters:
- INSTRET_WIDTH, 40, width of the optional retired-instruction counter; matches the time/cycle counter width.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous, active-low reset
- w_stall_i  in  1  global W-stage stall from pipeline control
- w_valid_i  in  1  instruction in W is valid (not excepted)
- w_fun_i  in  3  funct3; load width/sign
- w_load_i  in  1  W holds a load issued by X
- w_store_i  in  1  W holds a store issued by X
- w_rd_i  in  5  destination register
- w_rd_write_i  in  1  destination write enable
- w_rd_value_i  in  32  ALU/CSR result
- w_rd_shifter_i  in  32  shifter result
- w_rd_multiply_i  in  32  multiplier result
- w_rd_source_i  in  2  result select
- w_dm_addr_i  in  32  data address (low 2 bits used)
- dm_data_l_i  in  32  load data
- dm_load_done_i  in  1  load acknowledge, 1-cycle pulse
- dm_store_done_i  in  1  store acknowledge, 1-cycle pulse
- w_stall_req_o  out  1  W requests pipeline stall
- rf_rd_o  out  5  RF write address
- rf_rd_value_o  out  32  RF write data
- rf_rd_write_o  out  1  RF write strobe
- x_bypass_rd_o  out  5  registered last-written rd, for forwarding
- x_bypass_value_o  out  32  registered last-written value
- x_bypass_write_o  out  1  bypass entry valid
- instret_o  out  INSTRET_WIDTH  retired count (optional feature; 0 when compiled out)

Behaviour:
- Reset: asynchronous, active-low. All registers clear; FSM to IDLE; bypass outputs 0; capture register empty.
- FSM states:
  - IDLE: accept. Entered from reset and after each transaction completes.
  - WAIT_LD: load outstanding, no done yet.
  - WAIT_ST: store outstanding, no done yet.
- Transitions:
  - IDLE → WAIT_LD when w_valid_i & w_load_i & !dm_load_done_i & !w_stall_i.
  - IDLE → WAIT_ST when w_valid_i & w_store_i & !dm_store_done_i & !w_stall_i.
  - WAIT_LD/WAIT_ST → IDLE on the matching done.
- Stall request: w_stall_req_o is combinational, and is 1 when:
  - state is WAIT_LD and no dm_load_done_i this cycle, or
  - state is WAIT_ST and no dm_store_done_i this cycle, or
  - state is IDLE with a valid load/store whose done is not present this cycle.
- Zero-wait memory: done in the same cycle as entry means no stall and no state change.
- Done arriving while w_stall_i=1: data latched into a one-entry capture register with a valid flag. On stall release the instruction retires from the capture register; the flag clears on retire.
- Done without an outstanding request: ignored.
- Load alignment, byte lane = w_dm_addr_i[1:0]:
  - LB/LBU: select byte; LB sign-extends bit 7, LBU zero-extends.
  - LH/LHU: select halfword via addr[1]; LH sign-extends bit 15, LHU zero-extends.
  - LW: pass through.
  - Other funct3: zero.
- Misaligned accesses never reach W; no check is made here.
- Result select, non-load: source 0 = w_rd_value_i, 1 = shifter, 2 = multiply, 3 = w_rd_value_i.
- Retire (combinational, same cycle): instruction completes and !w_stall_i → rf_rd_write_o = w_rd_write_i & w_valid_i & (w_rd_i != 0). x0 is never written.
- Bypass: on each retiring write, x_bypass_* are registered one cycle later. A non-writing retire clears x_bypass_write_o.
- Reset mid-transaction: pending state is discarded; a late done after reset is ignored.

Optional Feature:
- Macro: URV_WB_INSTRET_EN.
- Defined: INSTRET_WIDTH-bit counter increments by 1 on every retire with w_valid_i=1. Includes stores and non-writing instructions. Wraps to 0 at all-ones.
- Undefined: no counter; instret_o is tied to 0.

Decomposition:
- Shared package / urv_defs gets: LDST_* funct3 codes; RD_SOURCE_ALU/SHIFTER/MULTIPLY/CSR encodings; WB FSM state encodings.
- One sub-module: urv_load_align, purely combinational (funct3, addr[1:0], data → aligned 32-bit value).

Test Plan:
- LB at addr 0x1003, data 0x80FF1234, done same cycle → rf value 0xFFFFFF80, no stall. Repeat as LBU → 0x00000080.
- LH at addr 0x2002, data 0x80FF1234, done 3 cycles late → stall_req high exactly 3 cycles, then value 0xFFFF80FF. LHU → 0x000080FF.
- Load to rd=0 with done → rf_rd_write_o stays 0; instret increments if enabled.
- Store, done while w_stall_i=1 → capture flag set, no write. Stall released → retires, FSM IDLE, instret +1.
- rst_n_i low while in WAIT_LD, then a stray dm_load_done_i after reset → all outputs 0, state IDLE, no write.
- Source 1 with shifter=0xDEADBEEF, rd=5 → rf write 0xDEADBEEF; next cycle x_bypass_rd_o=5, x_bypass_value_o=0xDEADBEEF, x_bypass_write_o=1.
